// File: rtl/potato1_loop_sequencer.sv
// Potato-1 loop sequencer: resolves "[" / "]" brackets, scans over skipped
// loop bodies with a nesting counter and drives the PC step strobes.
module potato1_loop_sequencer #(
    parameter int              DEPTH_W       = 4,
    parameter logic [3:0]      OP_LOOP_START = 4'hE,
    parameter logic [3:0]      OP_LOOP_END   = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [3:0]         instruction,
    input  logic               zeroflag,
    input  logic               iowait,
    output logic               exec_en,
    output logic               pc_inc,
    output logic               pc_dec,
    output logic               skipping,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SKIP_FWD  = 2'd1,
        SKIP_BACK = 2'd2,
        ERROR     = 2'd3
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t state;
    logic   step;
    logic   is_start;
    logic   is_end;

    // rst also suppresses the strobes so a reset cycle never moves the PC
    assign step     = instr_valid && !iowait && !rst;
    assign is_start = (instruction == OP_LOOP_START);
    assign is_end   = (instruction == OP_LOOP_END);
    assign skipping = (state == SKIP_FWD) || (state == SKIP_BACK);

    always_comb begin
        exec_en = 1'b0;
        pc_inc  = 1'b0;
        pc_dec  = 1'b0;
        if (step) begin
            case (state)
                RUN: begin
                    if (is_start && zeroflag) begin
                        pc_inc = 1'b1;
                    end else if (is_end && !zeroflag) begin
                        pc_dec = 1'b1;
                    end else begin
                        exec_en = 1'b1;
                        pc_inc  = 1'b1;
                    end
                end
                SKIP_FWD: pc_inc = 1'b1;
                SKIP_BACK: begin
                    if (is_start && depth == DEPTH_ONE) begin
                        pc_inc = 1'b1;
                    end else begin
                        pc_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            depth <= '0;
            err   <= 1'b0;
        end else if (instr_valid && !iowait) begin
            case (state)
                RUN: begin
                    if (is_start && zeroflag) begin
                        state <= SKIP_FWD;
                        depth <= DEPTH_ONE;
                    end else if (is_end && !zeroflag) begin
                        state <= SKIP_BACK;
                        depth <= DEPTH_ONE;
                    end
                end
                SKIP_FWD: begin
                    if (is_start) begin
                        if (depth == DEPTH_MAX) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            depth <= depth + DEPTH_ONE;
                        end
                    end else if (is_end) begin
                        if (depth == DEPTH_ONE) begin
                            state <= RUN;
                            depth <= '0;
                        end else begin
                            depth <= depth - DEPTH_ONE;
                        end
                    end
                end
                SKIP_BACK: begin
                    // mirror image of the forward scan: "]" nests, "[" unwinds
                    if (is_end) begin
                        if (depth == DEPTH_MAX) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            depth <= depth + DEPTH_ONE;
                        end
                    end else if (is_start) begin
                        if (depth == DEPTH_ONE) begin
                            state <= RUN;
                            depth <= '0;
                        end else begin
                            depth <= depth - DEPTH_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
